// File: rtl/mem_initiator.sv
// mem_initiator: requester-side sequencer for a 16x8 level-sensitive register RAM.
// Runs one request at a time through SETUP / ACCESS / HOLD and returns a response.
// Optional build macro MEM_WRITE_VERIFY_EN adds a VERIFY read-back state after writes.
module mem_initiator #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_WRITE,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_DATA_IN,
  output logic              MEM_OPCODE,
  input  logic [DATA_W-1:0] MEM_DATA_OUT
);

  localparam int unsigned CNT_W = 3;

`ifdef MEM_WRITE_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_VERIFY, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_RESP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_op_q, mem_op_d;
`ifdef MEM_WRITE_VERIFY_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  // Next-state and registered-output logic; the MEM_ADDRESS / MEM_DATA_IN registers
  // double as the request address/wdata latches, so they hold their value in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_op_d    = 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (REQ_VALID && req_ready_q) begin
          state_d     = S_SETUP;
          req_ready_d = 1'b0;
          op_d        = REQ_WRITE;
          mem_addr_d  = REQ_ADDR;
          mem_din_d   = REQ_WDATA;
          rsp_rdata_d = '0;
`ifdef MEM_WRITE_VERIFY_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        state_d  = S_ACCESS;
        cnt_d    = CNT_W'(WAIT_STATES);
        mem_op_d = op_q;
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          if (!op_q) rsp_rdata_d = MEM_DATA_OUT;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          mem_op_d = op_q;
        end
      end
      S_HOLD: begin
`ifdef MEM_WRITE_VERIFY_EN
        if (op_q) begin
          state_d = S_VERIFY;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = op_q;
        end
`else
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = op_q;
`endif
      end
`ifdef MEM_WRITE_VERIFY_EN
      S_VERIFY: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = op_q;
        rsp_rdata_d = MEM_DATA_OUT;
        rsp_err_d   = (MEM_DATA_OUT != mem_din_q);
      end
`endif
      S_RESP: begin
        if (RSP_READY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_op_q    <= 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_op_q    <= mem_op_d;
`ifdef MEM_WRITE_VERIFY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign REQ_READY   = req_ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_WRITE   = rsp_write_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign MEM_ADDRESS = mem_addr_q;
  assign MEM_DATA_IN = mem_din_q;
  assign MEM_OPCODE  = mem_op_q;
`ifdef MEM_WRITE_VERIFY_EN
  assign RSP_ERR     = rsp_err_q;
`else
  assign RSP_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: two mem_initiator instances (WAIT_STATES=1 and 0) share the request
// inputs, each with its own RAM model. With MEM_WRITE_VERIFY_EN the RAMs hold bit 0 at 0.
`timescale 1ns/1ps
module tb_mem_initiator;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned WS_A = 1;
  localparam int unsigned WS_B = 0;
`ifdef MEM_WRITE_VERIFY_EN
  localparam bit          VERIFY = 1'b1;
  localparam logic [DW-1:0] STUCK = 8'hFE;
`else
  localparam bit          VERIFY = 1'b0;
  localparam logic [DW-1:0] STUCK = 8'hFF;
`endif

  logic CLK = 1'b0;
  logic RST, REQ_VALID, REQ_WRITE, RSP_READY;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA;
  logic [1:0] req_ready, rsp_valid, rsp_write, rsp_err, mem_op;
  logic [1:0][DW-1:0] rsp_rdata, mem_din, mem_dout;
  logic [1:0][AW-1:0] mem_addr;
  logic [DW-1:0] ram [2][16];
  logic ram_clear;
  logic [DW-1:0] mdl [16];
  int unsigned total = 0;
  int unsigned bad = 0;

  int unsigned o_lat [2];
  int unsigned o_opcnt [2];
  int unsigned o_opfirst [2];
  logic [DW-1:0] o_rdata [2];
  bit o_wr [2], o_err [2], o_stable [2], o_rspstable [2];
  logic [1:0] o_pre_rr, o_idle_rr, o_idle_rv;
  logic [1:0][DW-1:0] held;
  bit seen_rsp, r_wr;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d, r_exp;
  int unsigned r_bp;

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;
  vec_t tbl [11];

  always #5 CLK = ~CLK;

  mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_A)) u_dut_a (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(req_ready[0]),
    .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(RSP_READY), .RSP_WRITE(rsp_write[0]),
    .RSP_RDATA(rsp_rdata[0]), .RSP_ERR(rsp_err[0]), .MEM_ADDRESS(mem_addr[0]),
    .MEM_DATA_IN(mem_din[0]), .MEM_OPCODE(mem_op[0]), .MEM_DATA_OUT(mem_dout[0]));

  mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_B)) u_dut_b (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(req_ready[1]),
    .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(RSP_READY), .RSP_WRITE(rsp_write[1]),
    .RSP_RDATA(rsp_rdata[1]), .RSP_ERR(rsp_err[1]), .MEM_ADDRESS(mem_addr[1]),
    .MEM_DATA_IN(mem_din[1]), .MEM_OPCODE(mem_op[1]), .MEM_DATA_OUT(mem_dout[1]));

  // Level-sensitive RAMs: read is combinational, write happens while OPCODE is high.
  assign mem_dout[0] = ram[0][mem_addr[0]];
  assign mem_dout[1] = ram[1][mem_addr[1]];

  always @(negedge CLK) begin
    if (ram_clear) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 16; j++) ram[i][j] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (mem_op[i]) ram[i][mem_addr[i]] <= mem_din[i] & STUCK;
    end
  end

  function automatic int unsigned ws_of(input int i);
    return (i == 0) ? WS_A : WS_B;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, then observe both instances cycle by cycle until each has
  // handed over its response (bounded to 40 cycles).
  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int unsigned bp);
    bit done [2];
    for (int i = 0; i < 2; i++) begin
      done[i] = 1'b0; o_lat[i] = 0; o_opcnt[i] = 0; o_opfirst[i] = 0;
      o_stable[i] = 1'b1; o_rspstable[i] = 1'b1; o_wr[i] = 1'b0; o_rdata[i] = '0; o_err[i] = 1'b0;
    end
    o_pre_rr  = req_ready;
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = a; REQ_WDATA = d; RSP_READY = 1'b0;
    for (int unsigned n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        REQ_VALID = 1'b0; REQ_WRITE = !wr; REQ_ADDR = ~a; REQ_WDATA = ~d;
      end
      RSP_READY = (n >= bp);
      for (int i = 0; i < 2; i++) begin
        if (!done[i]) begin
          if (mem_op[i]) begin
            o_opcnt[i]++;
            if (o_opfirst[i] == 0) o_opfirst[i] = n;
          end
          if (mem_addr[i] !== a || mem_din[i] !== d) o_stable[i] = 1'b0;
          if (rsp_valid[i]) begin
            if (o_lat[i] == 0) begin
              o_lat[i] = n; o_wr[i] = rsp_write[i]; o_rdata[i] = rsp_rdata[i]; o_err[i] = rsp_err[i];
            end else if (rsp_write[i] !== o_wr[i] || rsp_rdata[i] !== o_rdata[i] || rsp_err[i] !== o_err[i]) begin
              o_rspstable[i] = 1'b0;
            end
            if (RSP_READY) done[i] = 1'b1;
          end
        end
      end
      if (done[0] && done[1]) break;
    end
    @(negedge CLK);
    o_idle_rr = req_ready;
    o_idle_rv = rsp_valid;
    RSP_READY = 1'b0;
  endtask

  task automatic check_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_rdata, input bit exp_err, input int unsigned bp);
    run_txn(wr, a, d, bp);
    chk("pre_ready", 32'(o_pre_rr), 32'h3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("latency[%0d]", i), o_lat[i], 4 + ws_of(i) + ((VERIFY && wr) ? 1 : 0));
      chk($sformatf("rsp_write[%0d]", i), 32'(o_wr[i]), 32'(wr));
      chk($sformatf("rsp_rdata[%0d]", i), 32'(o_rdata[i]), 32'(exp_rdata));
      chk($sformatf("rsp_err[%0d]", i), 32'(o_err[i]), 32'(exp_err));
      chk($sformatf("opcode_cycles[%0d]", i), o_opcnt[i], wr ? 1 + ws_of(i) : 0);
      chk($sformatf("opcode_first[%0d]", i), o_opfirst[i], wr ? 2 : 0);
      chk($sformatf("addr_data_stable[%0d]", i), 32'(o_stable[i]), 32'h1);
      chk($sformatf("rsp_stable[%0d]", i), 32'(o_rspstable[i]), 32'h1);
    end
    chk("idle_ready", 32'(o_idle_rr), 32'h3);
    chk("idle_rsp_valid", 32'(o_idle_rv), 32'h0);
    if (wr) mdl[a] = d & STUCK;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'h3, 8'hA5, VERIFY ? 8'hA4 : 8'h00, VERIFY};
    tbl[1]  = '{1'b0, 4'h3, 8'h00, VERIFY ? 8'hA4 : 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 8'hFF, VERIFY ? 8'hFE : 8'h00, VERIFY};
    tbl[3]  = '{1'b0, 4'hF, 8'h00, VERIFY ? 8'hFE : 8'hFF, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 8'h5A, VERIFY ? 8'h5A : 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 8'h00, 8'h5A, 1'b0};
    tbl[6]  = '{1'b1, 4'h7, 8'h81, VERIFY ? 8'h80 : 8'h00, VERIFY};
    tbl[7]  = '{1'b0, 4'h7, 8'h00, VERIFY ? 8'h80 : 8'h81, 1'b0};
    tbl[8]  = '{1'b1, 4'h7, 8'h80, VERIFY ? 8'h80 : 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 4'h7, 8'h00, 8'h80, 1'b0};
    tbl[10] = '{1'b0, 4'h3, 8'h00, VERIFY ? 8'hA4 : 8'hA5, 1'b0};

    RST = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    RSP_READY = 1'b0; ram_clear = 1'b1;
    for (int j = 0; j < 16; j++) mdl[j] = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0; ram_clear = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_req_ready[%0d]", i), 32'(req_ready[i]), 32'h1);
      chk($sformatf("rst_rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'h0);
      chk($sformatf("rst_opcode[%0d]", i), 32'(mem_op[i]), 32'h0);
      chk($sformatf("rst_rsp_err[%0d]", i), 32'(rsp_err[i]), 32'h0);
      chk($sformatf("rst_mem_addr[%0d]", i), 32'(mem_addr[i]), 32'h0);
    end

    // Directed table.
    for (int k = 0; k < 11; k++) begin
      check_txn(tbl[k].wr, tbl[k].a, tbl[k].d, tbl[k].exp_rdata, tbl[k].exp_err, (k % 3) * 3);
      if (k == 0)
        for (int i = 0; i < 2; i++)
          chk($sformatf("ram_entry3[%0d]", i), 32'(ram[i][3]), 32'(tbl[0].d & STUCK));
    end

    // Back-pressure: response held while busy-time requests to address F are ignored.
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 4'h3; RSP_READY = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    for (int n = 0; n < 20 && rsp_valid != 2'b11; n++) @(negedge CLK);
    chk("bp_valid", 32'(rsp_valid), 32'h3);
    held = rsp_rdata;
    chk("bp_rdata_a", 32'(held[0]), 32'(mdl[3]));
    chk("bp_rdata_b", 32'(held[1]), 32'(mdl[3]));
    for (int n = 0; n < 4; n++) begin
      REQ_VALID = (n % 2 == 0); REQ_WRITE = 1'b1; REQ_ADDR = 4'hF; REQ_WDATA = 8'h3C;
      @(negedge CLK);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h3);
      chk("bp_hold_rdata", 32'(rsp_rdata), 32'(held));
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_opcode", 32'(mem_op), 32'h0);
      chk("bp_mem_addr", 32'(mem_addr), 32'h33);
    end
    REQ_VALID = 1'b0; RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    chk("bp_release_ready", 32'(req_ready), 32'h3);
    chk("bp_release_valid", 32'(rsp_valid), 32'h0);
    @(negedge CLK);
    chk("bp_no_accept", 32'(mem_addr), 32'h33);

    // Reset during the first ACCESS cycle of a write.
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 4'h9; REQ_WDATA = 8'h3D; RSP_READY = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("rstw_opcode_before", 32'(mem_op), 32'h3);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstw_opcode", 32'(mem_op), 32'h0);
    chk("rstw_req_ready", 32'(req_ready), 32'h3);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'h0);
    seen_rsp = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid != 2'b00) seen_rsp = 1'b1;
    end
    chk("rstw_no_response", 32'(seen_rsp), 32'h0);
    RSP_READY = 1'b0;
    mdl[9] = 8'h3D & STUCK;
    check_txn(1'b0, 4'h9, 8'h00, mdl[9], 1'b0, 0);

    // Randomized traffic against the memory model.
    for (int k = 0; k < 40; k++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_a  = 4'($urandom_range(0, 15));
      r_d  = 8'($urandom_range(0, 255));
      r_bp = $urandom_range(0, 9);
      if (r_wr) r_exp = VERIFY ? (r_d & STUCK) : 8'h00;
      else      r_exp = mdl[r_a];
      check_txn(r_wr, r_a, r_d, r_exp, VERIFY && r_wr && ((r_d & STUCK) != r_d), r_bp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Requester-side controller for the 16x8 level-sensitive register RAM.
- Accepts one read or write request at a time from the CPU datapath over a valid/ready handshake.
- Sequences the RAM's ADDRESS, DATA_IN and OPCODE lines with setup, access and hold phases, and returns read data and completion over a valid/ready response channel.
- Keeps OPCODE low except during a write's access phase, so the RAM never sees a spurious write.

Parameters:
- ADDR_W, 4, address width; matches the 16-entry RAM.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra access cycles beyond the first; legal range 0..7.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_W  target address.
- REQ_WDATA  in  DATA_W  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_WRITE  out  1  echoes the op of the completed request.
- RSP_RDATA  out  DATA_W  read data.
- RSP_ERR  out  1  write-verify mismatch.
- MEM_ADDRESS  out  ADDR_W  drives RAM ADDRESS.
- MEM_DATA_IN  out  DATA_W  drives RAM DATA_IN.
- MEM_OPCODE  out  1  drives RAM OPCODE; 1 = write.
- MEM_DATA_OUT  in  DATA_W  from RAM DATA_OUT.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: every output is registered and resets to 0, except REQ_READY, which is 1. State resets to IDLE.
- FSM states: IDLE, SETUP, ACCESS, HOLD, [VERIFY], RESP.
- IDLE:
  - REQ_READY=1 and MEM_OPCODE=0.
  - Handshake is REQ_VALID&REQ_READY at an edge.
  - On handshake, latch addr, wdata and op into internal registers; next state is SETUP.
- SETUP (1 cycle):
  - REQ_READY=0.
  - MEM_ADDRESS and MEM_DATA_IN are driven from the latches; MEM_OPCODE=0.
- ACCESS (1+WAIT_STATES cycles, counted by a down-counter):
  - MEM_OPCODE = latched op; address and data stay stable.
  - For a read, MEM_DATA_OUT is sampled into RSP_RDATA on the last ACCESS cycle.
- HOLD (1 cycle):
  - MEM_OPCODE=0; address and data are still held.
  - Next state is VERIFY (write with macro) or RESP.
- RESP:
  - RSP_VALID=1; RSP_WRITE, RSP_RDATA and RSP_ERR are stable.
  - Remains in RESP while RSP_READY=0.
  - On RSP_VALID&RSP_READY, go to IDLE; RSP_VALID clears and REQ_READY sets on the next cycle.
- Latency: for a read, or a write without the macro, RSP_VALID rises in cycle 4+WAIT_STATES after the accept edge (5 for the default).
- Outstanding requests: exactly one. No new request is accepted in the same cycle as a response handshake.
- MEM_ADDRESS and MEM_DATA_IN keep their last values while in IDLE; only MEM_OPCODE is forced 0.
- Write responses: RSP_RDATA=0 (unless VERIFY) and RSP_ERR=0.
- Request changes while busy: changes on REQ_* while REQ_READY=0 are ignored.
- Reset mid-operation: RST in any state gives, at the next edge, state IDLE, MEM_OPCODE=0, RSP_VALID=0 and REQ_READY=1. A partially written location is left as-is.
- WAIT_STATES=0: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MEM_WRITE_VERIFY_EN.
- When defined:
  - Writes pass through VERIFY (1 cycle) after HOLD.
  - In VERIFY, MEM_OPCODE=0 at the same address and MEM_DATA_OUT is sampled.
  - RSP_RDATA = readback value; RSP_ERR = (readback != latched wdata).
  - Write latency increases by 1 cycle. Reads are unchanged.
- When undefined: there is no VERIFY state, RSP_ERR is constant 0, and write RSP_RDATA=0.

Test Plan:
- Reset values: assert RST for 2 cycles, then release -> REQ_READY=1, RSP_VALID=0, MEM_OPCODE=0, RSP_ERR=0, MEM_ADDRESS=0.
- Write timing: write addr 4'h3, data 8'hA5, WAIT_STATES=1, RSP_READY=1 -> MEM_OPCODE=1 for exactly 2 cycles with MEM_ADDRESS=3 and MEM_DATA_IN=A5 stable one cycle before and after. RSP_VALID=1 with RSP_WRITE=1 in cycle 5. RAM model entry 3 = A5.
- Read timing: read addr 3 following the write -> MEM_OPCODE stays 0 throughout; RSP_RDATA=8'hA5 and RSP_WRITE=0 in cycle 5.
- Back-pressure: hold RSP_READY=0 for 4 cycles, and toggle REQ_VALID with addr F -> RSP_VALID and RSP_RDATA stay constant, REQ_READY=0, no MEM activity. One cycle after RSP_READY=1, REQ_READY=1.
- Reset mid-write: assert RST during the first ACCESS cycle of a write -> MEM_OPCODE=0 and REQ_READY=1 next cycle; no response is issued.
- Write verify (macro on): the bench RAM model forces bit 0 stuck at 0; write 8'h81 -> RSP_ERR=1 and RSP_RDATA=8'h80, latency 6. Writing 8'h80 -> RSP_ERR=0.
